icache_line: RTL and testbench
==============================

ICACHE_LINE -- requirements
Module: icache_line

Interface
REQ-001 Parameter LOG_SETS, default 6, log2 of line count (64 lines).
REQ-002 Parameter LOG_WORDS, default 2, log2 of 32-bit words per line (4 words, 16 B).
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 rdy  input  1  global enable; 0 freezes all state and outputs.
REQ-006 read  input  1  fetch request; held by requester until read_ok.
REQ-007 read_addr  input  32  byte address; stable while read high; bits [1:0] ignored.
REQ-008 flush  input  1  one-cycle pulse invalidating all lines.
REQ-009 read_ans  output  32  fetched instruction word, valid when read_ok=1.
REQ-010 read_ok  output  1  one-cycle completion pulse.
REQ-011 memctrl_read  output  1  word read request to memory controller.
REQ-012 memctrl_addr  output  32  byte address of requested word, word-aligned.
REQ-013 memctrl_ok  input  1  one-cycle pulse; memctrl_rtn valid same cycle.
REQ-014 memctrl_rtn  input  32  returned word.

Function
REQ-015 Address split: offset=[LOG_WORDS+1:2], index=[LOG_SETS+LOG_WORDS+1:LOG_WORDS+2], tag=[31:LOG_SETS+LOG_WORDS+2]; direct-mapped.
REQ-016 States: IDLE, REFILL, REST; reset state IDLE.
REQ-017 IDLE, read=1, flush=0, valid[index] and tag match: next cycle read_ok=1, read_ans=word[index][offset], go REST (hit latency 1 cycle).
REQ-018 IDLE, read=1, flush=0, miss: next cycle memctrl_read=1, memctrl_addr={tag,index,0,2'b00}, word counter=0, go REFILL.
REQ-019 REFILL, memctrl_ok=1: store memctrl_rtn at word[counter]; memctrl_read=0 next cycle; if counter<2^LOG_WORDS-1, counter+1 and memctrl_read=1 with next word address the cycle after (one idle cycle between words).
REQ-020 REFILL, last word returned: write tag, set valid, read_ok=1 with requested word (bypassed if it is the last word), go REST.
REQ-021 REST: read ignored one cycle, read_ok=0, go IDLE.
REQ-022 read_ok deasserted every enabled cycle except the completion cycle.
REQ-023 memctrl_ok while not REFILL ignored.
REQ-024 flush in IDLE: all valid cleared next cycle; a simultaneous read is not serviced that cycle (flush wins, requester keeps read high).
REQ-025 flush in REFILL or REST: recorded; refill completes and delivers read_ok, refilled line left invalid, all valids cleared on return to IDLE.
REQ-026 rdy=0: no state, counter, array or output change; memctrl_ok arriving while rdy=0 is lost (memory controller shares rdy).

Reset
REQ-027 rst: state=IDLE, all valid=0, read_ok=0, memctrl_read=0, counter=0, pending flush=0; read_ans, memctrl_addr, data and tag arrays not reset.
REQ-028 rst mid-REFILL abandons refill; partial line stays invalid; rst has priority over rdy.

Configuration
REQ-029 Macro ICACHE_STATS_EN defined: outputs hit_cnt (32) and miss_cnt (32) added, reset to 0, +1 on each hit/miss decision, wrap 0xFFFFFFFF->0, unaffected by flush.
REQ-030 ICACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-031 const.v holds defaults ICACHE_LOG_SETS, ICACHE_LOG_WORDS and state encodings.
REQ-032 One sub-module icache_data_ram: 2^(LOG_SETS+LOG_WORDS) x 32 array, synchronous write, asynchronous read; tags and valids stay in icache_line.

Verification
REQ-033 Cold miss: read 0x00001000, memctrl returns 0xA0,0xA1,0xA2,0xA3 for 0x1000..0x100C -> four memctrl requests, read_ok with read_ans=0xA0.
REQ-034 Warm hit: then read 0x00001008 -> read_ok exactly 1 cycle later, read_ans=0xA2, no memctrl_read.
REQ-035 Conflict: read 0x00001400 (same index, new tag) -> refill from 0x1400; re-read 0x1000 misses again.
REQ-036 Flush: pulse flush with read 0x1008 held -> flush taken first, then miss refill of 0x1000 line.
REQ-037 Stall/reset: rdy=0 for 5 cycles mid-refill -> outputs frozen, refill resumes; rst after second word -> line invalid, next read misses.
REQ-038 With ICACHE_STATS_EN: sequence of REQ-033..035 -> hit_cnt=1, miss_cnt=3.

Source files
------------

// File: rtl/icache_line_pkg.sv
// Shared defaults and FSM encoding for the direct-mapped instruction cache line controller.
package icache_line_pkg;

  localparam int ICACHE_LOG_SETS  = 6;
  localparam int ICACHE_LOG_WORDS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_REST   = 2'd2
  } state_e;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction word store: synchronous write, asynchronous read.
module icache_data_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [1<<AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/icache_line.sv
// Direct-mapped instruction cache with word-serial refill.
// Define ICACHE_STATS_EN to add hit_cnt / miss_cnt counter outputs.
module icache_line
  import icache_line_pkg::*;
#(
  parameter int LOG_SETS  = ICACHE_LOG_SETS,
  parameter int LOG_WORDS = ICACHE_LOG_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        read,
  input  logic [31:0] read_addr,
  input  logic        flush,
  output logic [31:0] read_ans,
  output logic        read_ok,
  output logic        memctrl_read,
  output logic [31:0] memctrl_addr,
  input  logic        memctrl_ok,
  input  logic [31:0] memctrl_rtn
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int SETS    = 1 << LOG_SETS;
  localparam int IDX_LSB = LOG_WORDS + 2;
  localparam int TAG_LSB = LOG_SETS + LOG_WORDS + 2;
  localparam int TAG_W   = 32 - TAG_LSB;

  logic [LOG_WORDS-1:0] req_off;
  logic [LOG_SETS-1:0]  req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic                 unused_addr_bits;

  assign req_off          = read_addr[IDX_LSB-1:2];
  assign req_idx          = read_addr[TAG_LSB-1:IDX_LSB];
  assign req_tag          = read_addr[31:TAG_LSB];
  assign unused_addr_bits = ^read_addr[1:0];

  state_e               state_q;
  logic [LOG_WORDS-1:0] cnt_q;
  logic                 flush_pend_q;
  logic [SETS-1:0]      valid_q;
  logic [TAG_W-1:0]     tag_q [SETS];
  logic                 read_ok_q, memctrl_read_q;
  logic [31:0]          read_ans_q, memctrl_addr_q;

  logic        hit, ram_we, flush_now;
  logic [31:0] rd_word;

  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign flush_now = flush || flush_pend_q;
  // Only accept a returned word while a request is actually outstanding.
  assign ram_we    = !rst && rdy && (state_q == ST_REFILL) && memctrl_read_q && memctrl_ok;

  icache_data_ram #(.AW(LOG_SETS + LOG_WORDS)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i ({req_idx, cnt_q}),
    .wdata_i (memctrl_rtn),
    .raddr_i ({req_idx, req_off}),
    .rdata_o (rd_word)
  );

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      flush_pend_q   <= 1'b0;
      valid_q        <= '0;
      read_ok_q      <= 1'b0;
      memctrl_read_q <= 1'b0;
`ifdef ICACHE_STATS_EN
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
`endif
    end else if (rdy) begin
      read_ok_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (read) begin
            if (hit) begin
              read_ok_q  <= 1'b1;
              read_ans_q <= rd_word;
              state_q    <= ST_REST;
`ifdef ICACHE_STATS_EN
              hit_cnt_q  <= hit_cnt_q + 32'd1;
`endif
            end else begin
              memctrl_read_q <= 1'b1;
              memctrl_addr_q <= {req_tag, req_idx, {LOG_WORDS{1'b0}}, 2'b00};
              cnt_q          <= '0;
              state_q        <= ST_REFILL;
`ifdef ICACHE_STATS_EN
              miss_cnt_q     <= miss_cnt_q + 32'd1;
`endif
            end
          end
        end
        ST_REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          // Request low here means the idle gap after a returned word.
          if (!memctrl_read_q) begin
            memctrl_read_q <= 1'b1;
            memctrl_addr_q <= {req_tag, req_idx, cnt_q, 2'b00};
          end else if (memctrl_ok) begin
            memctrl_read_q <= 1'b0;
            if (&cnt_q) begin
              tag_q[req_idx] <= req_tag;
              if (!flush_now) valid_q[req_idx] <= 1'b1;
              read_ok_q  <= 1'b1;
              read_ans_q <= (req_off == cnt_q) ? memctrl_rtn : rd_word;
              state_q    <= ST_REST;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_REST: begin
          state_q <= ST_IDLE;
          if (flush_now) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign read_ok      = read_ok_q;
  assign read_ans     = read_ans_q;
  assign memctrl_read = memctrl_read_q;
  assign memctrl_addr = memctrl_addr_q;

endmodule

// File: tb/tb_icache_line.sv
// Self-checking bench for icache_line: directed scenarios plus randomized reads against a cache model.
module tb_icache_line;
  import icache_line_pkg::*;

  localparam int LS   = ICACHE_LOG_SETS;
  localparam int LW   = ICACHE_LOG_WORDS;
  localparam int W    = 1 << LW;
  localparam int SETS = 1 << LS;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, read = 1'b0, flush = 1'b0, memctrl_ok = 1'b0;
  logic [31:0] read_addr = '0, memctrl_rtn = '0;
  logic [31:0] read_ans, memctrl_addr;
  logic        read_ok, memctrl_read;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_line dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .read         (read),
    .read_addr    (read_addr),
    .flush        (flush),
    .read_ans     (read_ans),
    .read_ok      (read_ok),
    .memctrl_read (memctrl_read),
    .memctrl_addr (memctrl_addr),
    .memctrl_ok   (memctrl_ok),
    .memctrl_rtn  (memctrl_rtn)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Per-read observations
  logic [31:0] req_q[$];
  int          o_lat, o_sd, o_frozen;
  logic [31:0] o_ans;
  bit          o_aborted, rest_flush;
  logic        o_ok_after;

  // Reference cache contents
  bit          m_valid[SETS];
  int unsigned m_tag[SETS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ((a >> 4) == 32'h100) return 32'hA0 + ((a >> 2) & 32'(W - 1));
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Drives one fetch to completion while acting as the memory controller.
  task automatic do_read(input logic [31:0] a, input int flush_cyc, input int stall_at, input int rst_words);
    int dly = 0, words = 0;
    bit in_req = 0;
    logic [65:0] snap, cur;
    req_q.delete();
    o_lat = -1; o_sd = 0; o_frozen = 0; o_aborted = 0; o_ok_after = 1'b0; o_ans = '0;
    read = 1'b1; read_addr = a;
    snap = {read_ok, memctrl_read, read_ans, memctrl_addr};
    for (int i = 0; i < 200; i++) begin
      memctrl_ok = 1'b0;
      flush = (i == flush_cyc);
      rdy = !(stall_at >= 0 && i >= stall_at && i < stall_at + 5);
      if (rst_words >= 0 && words == rst_words) begin
        rst = 1'b1; read = 1'b0; flush = 1'b0; rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; o_aborted = 1'b1;
        return;
      end
      if (rdy && memctrl_read) begin
        if (!in_req) begin
          in_req = 1; req_q.push_back(memctrl_addr);
          dly = int'($urandom_range(0, 2)); o_sd += dly;
        end
        if (dly == 0) begin
          memctrl_ok = 1'b1; memctrl_rtn = mem_word(memctrl_addr); in_req = 0; words++;
        end else dly--;
      end
      @(posedge clk); #1;
      cur = {read_ok, memctrl_read, read_ans, memctrl_addr};
      if (!rdy && cur !== snap) o_frozen++;
      snap = cur;
      if (read_ok) begin
        o_lat = i + 1; o_ans = read_ans;
        break;
      end
    end
    memctrl_ok = 1'b0; rdy = 1'b1; read = 1'b0;
    flush = rest_flush;
    if (o_lat < 0) begin flush = 1'b0; return; end
    @(posedge clk); #1;
    flush = 1'b0;
    o_ok_after = read_ok;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (read_ok !== 1'b0) begin errors++; $display("FAIL reset_read_ok got %b want 0", read_ok); end
    checks++; if (memctrl_read !== 1'b0) begin errors++; $display("FAIL reset_memctrl_read got %b want 0", memctrl_read); end
`ifdef ICACHE_STATS_EN
    checks++; if (hit_cnt !== 0 || miss_cnt !== 0) begin errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
    rst = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss;
    do_read(32'h1000, -1, -1, -1);
    checks++; if (o_ans !== 32'hA0) begin errors++; $display("FAIL cold_ans got %h want a0", o_ans); end
    checks++; if (req_q.size() != W) begin errors++; $display("FAIL cold_nreq got %0d want %0d", req_q.size(), W); end
    for (int k = 0; k < req_q.size(); k++) begin
      checks++; if (req_q[k] !== 32'h1000 + 32'(4 * k)) begin errors++; $display("FAIL cold_addr%0d got %h want %h", k, req_q[k], 32'h1000 + 32'(4 * k)); end
    end
    checks++; if (o_lat != 2 * W + o_sd) begin errors++; $display("FAIL cold_lat got %0d want %0d", o_lat, 2 * W + o_sd); end
    checks++; if (o_ok_after !== 1'b0) begin errors++; $display("FAIL cold_ok_pulse got %b want 0", o_ok_after); end
  endtask

  task automatic test_warm_hit;
    do_read(32'h1008, -1, -1, -1);
    checks++; if (o_lat != 1) begin errors++; $display("FAIL hit_lat got %0d want 1", o_lat); end
    checks++; if (o_ans !== 32'hA2) begin errors++; $display("FAIL hit_ans got %h want a2", o_ans); end
    checks++; if (req_q.size() != 0) begin errors++; $display("FAIL hit_nreq got %0d want 0", req_q.size()); end
  endtask

  task automatic test_conflict;
    do_read(32'h1400, -1, -1, -1);
    checks++; if (req_q.size() != W || req_q[0] !== 32'h1400) begin errors++; $display("FAIL conflict_refill got n=%0d want n=%0d from 1400", req_q.size(), W); end
    checks++; if (o_ans !== mem_word(32'h1400)) begin errors++; $display("FAIL conflict_ans got %h want %h", o_ans, mem_word(32'h1400)); end
    do_read(32'h1000, -1, -1, -1);
    checks++; if (req_q.size() != W) begin errors++; $display("FAIL conflict_reread got n=%0d want %0d", req_q.size(), W); end
    checks++; if (o_ans !== 32'hA0) begin errors++; $display("FAIL conflict_reread_ans got %h want a0", o_ans); end
`ifdef ICACHE_STATS_EN
    checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd3) begin errors++; $display("FAIL stats got %0d/%0d want 1/3", hit_cnt, miss_cnt); end
`endif
  endtask

  task automatic test_flush;
    do_read(32'h1008, 0, -1, -1);
    checks++; if (req_q.size() != W) begin errors++; $display("FAIL flush_idle_nreq got %0d want %0d", req_q.size(), W); end
    checks++; if (o_lat != 2 * W + o_sd + 1) begin errors++; $display("FAIL flush_idle_lat got %0d want %0d", o_lat, 2 * W + o_sd + 1); end
    checks++; if (o_ans !== 32'hA2) begin errors++; $display("FAIL flush_idle_ans got %h want a2", o_ans); end
    do_read(32'h2004, 3, -1, -1);
    checks++; if (o_ans !== mem_word(32'h2004)) begin errors++; $display("FAIL flush_refill_ans got %h want %h", o_ans, mem_word(32'h2004)); end
    do_read(32'h2000, -1, -1, -1);
    checks++; if (req_q.size() != W) begin errors++; $display("FAIL flush_refill_invalid got n=%0d want %0d", req_q.size(), W); end
    rest_flush = 1'b1;
    do_read(32'h200C, -1, -1, -1);
    rest_flush = 1'b0;
    checks++; if (o_lat != 1) begin errors++; $display("FAIL flush_rest_hit got lat %0d want 1", o_lat); end
    do_read(32'h200C, -1, -1, -1);
    checks++; if (req_q.size() != W) begin errors++; $display("FAIL flush_rest_invalid got n=%0d want %0d", req_q.size(), W); end
  endtask

  task automatic test_stall_reset;
    do_read(32'h3000, -1, 3, -1);
    checks++; if (o_frozen != 0) begin errors++; $display("FAIL stall_frozen got %0d changes want 0", o_frozen); end
    checks++; if (o_lat != 2 * W + o_sd + 5) begin errors++; $display("FAIL stall_lat got %0d want %0d", o_lat, 2 * W + o_sd + 5); end
    checks++; if (o_ans !== mem_word(32'h3000)) begin errors++; $display("FAIL stall_ans got %h want %h", o_ans, mem_word(32'h3000)); end
    do_read(32'h4000, -1, -1, 2);
    checks++; if (o_aborted !== 1'b1 || req_q.size() != 2) begin errors++; $display("FAIL rst_abort got ab=%b n=%0d want ab=1 n=2", o_aborted, req_q.size()); end
    checks++; if (read_ok !== 1'b0 || memctrl_read !== 1'b0) begin errors++; $display("FAIL rst_outputs got ok=%b mr=%b want 0/0", read_ok, memctrl_read); end
    do_read(32'h4004, -1, -1, -1);
    checks++; if (req_q.size() != W || o_ans !== mem_word(32'h4004)) begin errors++; $display("FAIL rst_remiss got n=%0d ans=%h want n=%0d ans=%h", req_q.size(), o_ans, W, mem_word(32'h4004)); end
    do_read(32'h3000, -1, -1, -1);
    checks++; if (req_q.size() != W) begin errors++; $display("FAIL rst_clears_valid got n=%0d want %0d", req_q.size(), W); end
  endtask

  task automatic test_random;
    int unsigned picks[4];
    picks = '{0, 1, 5, SETS - 1};
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    for (int s = 0; s < SETS; s++) m_valid[s] = 0;
    for (int n = 0; n < 60; n++) begin
      int unsigned ix, tg;
      int st, exp_lat;
      bit exp_hit;
      logic [31:0] a, base;
      ix = picks[$urandom_range(0, 3)];
      tg = $urandom_range(0, 2);
      a = (32'(tg) << (LS + LW + 2)) | (32'(ix) << (LW + 2)) |
          (32'($urandom_range(0, W - 1)) << 2) | 32'($urandom_range(0, 3));
      base = a & ~32'(4 * W - 1);
      exp_hit = m_valid[ix] && m_tag[ix] == tg;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_read(a, -1, st, -1);
      exp_lat = exp_hit ? ((st == 0) ? 6 : 1) : 2 * W + o_sd + ((st >= 0) ? 5 : 0);
      checks++; if (o_ans !== mem_word(a & ~32'd3)) begin errors++; $display("FAIL rnd%0d_ans a=%h got %h want %h", n, a, o_ans, mem_word(a & ~32'd3)); end
      checks++; if (o_lat != exp_lat) begin errors++; $display("FAIL rnd%0d_lat a=%h got %0d want %0d", n, a, o_lat, exp_lat); end
      checks++; if (req_q.size() != (exp_hit ? 0 : W)) begin errors++; $display("FAIL rnd%0d_nreq a=%h got %0d want %0d", n, a, req_q.size(), exp_hit ? 0 : W); end
      for (int k = 0; k < req_q.size(); k++) begin
        checks++; if (req_q[k] !== base + 32'(4 * k)) begin errors++; $display("FAIL rnd%0d_addr%0d got %h want %h", n, k, req_q[k], base + 32'(4 * k)); end
      end
      checks++; if (o_frozen != 0 || o_ok_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_quiet got frz=%0d ok=%b want 0/0", n, o_frozen, o_ok_after); end
      m_valid[ix] = 1; m_tag[ix] = tg;
      case ($urandom_range(0, 9))
        0: begin
          flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
          for (int s = 0; s < SETS; s++) m_valid[s] = 0;
        end
        1: begin
          memctrl_ok = 1'b1; memctrl_rtn = 32'hDEADBEEF; @(posedge clk); #1; memctrl_ok = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    rest_flush = 1'b0;
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_flush();
    test_stall_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
